sprite_color_mapper: RTL and testbench

Parametrised successor to the single-ball colour mapper. Produces VGA RGB for the PacMan scene from the maze ROM plus NUM_SPRITES circular sprites (PacMan and ghosts), using a writable palette. Sprite positions are captured once per frame so sprites never tear, and a frightened/flash mode is driven by a frame counter. Synchronous ROM latency is absorbed by a fixed 2-cycle pixel pipeline. Sits between the VGA controller and the VGA DAC outputs.

---
 rtl/pacman_vga_pkg.sv | 43 ++++
 rtl/sprite_hit.sv | 42 ++++
 rtl/sprite_color_mapper.sv | 202 ++++++++++++++++++++
 tb/tb_sprite_color_mapper.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_vga_pkg.sv
// rtl/pacman_vga_pkg.sv - shared types and constants for the PacMan VGA colour path
//
// Purpose: screen geometry, the 24-bit RGB struct, palette index constants and
// the palette contents loaded at reset.
package pacman_vga_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int PAL_ENTRIES = 16;

  typedef logic [3:0] pal_idx_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Fixed palette roles; every other entry is a free sprite colour slot.
  localparam pal_idx_t PAL_BG     = 4'd0;
  localparam pal_idx_t PAL_MAZE   = 4'd1;
  localparam pal_idx_t PAL_FRIGHT = 4'd8;
  localparam pal_idx_t PAL_FLASH  = 4'd9;

  // Palette contents after reset: background, maze blue, PacMan yellow, the four
  // ghost colours, then the frightened blue and the flash white.
  function automatic rgb_t reset_palette(input pal_idx_t idx);
    rgb_t c;
    case (idx)
      4'd1:    c = 24'h2121FF;
      4'd2:    c = 24'hFFFF00;
      4'd3:    c = 24'hFF0000;
      4'd4:    c = 24'hFFB8FF;
      4'd5:    c = 24'h00FFFF;
      4'd6:    c = 24'hFFB852;
      4'd8:    c = 24'h2121FF;
      4'd9:    c = 24'hFFFFFF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sprite_hit.sv
// rtl/sprite_hit.sv - single circular sprite coverage test
//
// Purpose: reports whether pixel (draw_x, draw_y) lies inside the enabled circle
// of the given centre and radius (boundary included).
// Ports:
//   draw_x, draw_y     in  10  current pixel
//   center_x, center_y in  10  sprite centre
//   radius             in  10  circle radius
//   en                 in  1   sprite enable
//   hit                out 1   pixel is covered by this sprite
module sprite_hit (
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic [9:0] center_x,
  input  logic [9:0] center_y,
  input  logic [9:0] radius,
  input  logic       en,
  output logic       hit
);

  // Offsets are signed 11-bit so a sprite near the left/top edge clips instead
  // of wrapping around to the far side of the screen.
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic signed [21:0] dx_sq;
  logic signed [21:0] dy_sq;
  logic        [21:0] dist_sq;
  logic        [21:0] r_sq;

  assign dx = $signed({1'b0, draw_x}) - $signed({1'b0, center_x});
  assign dy = $signed({1'b0, draw_y}) - $signed({1'b0, center_y});

  assign dx_sq = 22'(dx) * 22'(dx);
  assign dy_sq = 22'(dy) * 22'(dy);

  // Both squares are at most 1023^2, so their sum still fits in 22 bits.
  assign dist_sq = $unsigned(dx_sq) + $unsigned(dy_sq);
  assign r_sq    = 22'(radius) * 22'(radius);

  assign hit = en && (dist_sq <= r_sq);

endmodule

// File: rtl/sprite_color_mapper.sv
// rtl/sprite_color_mapper.sv - maze + sprite colour mapper with writable palette
//
// Purpose: turns the VGA pixel position into RGB for the PacMan scene. Draws
// NUM_SPRITES circles over the maze bitmap held in an external synchronous ROM,
// through a 16-entry writable palette, with a fixed 2-cycle pixel latency.
// Ports:
//   Clk, Reset            in   pixel clock, synchronous active-high reset
//   DrawX, DrawY, blank   in   pixel position, active-low blank
//   sprite_x/y/en/cidx/r  in   sprite state, captured once per frame
//   fright, fright_end    in   frightened mode / flashing phase (live)
//   pal_we/addr/data      in   palette write port
//   maze_rom_addr         out  maze ROM address (combinational)
//   maze_rom_data         in   maze ROM bit, one cycle after the address
//   Red, Green, Blue      out  registered pixel colour
module sprite_color_mapper
  import pacman_vga_pkg::*;
#(
  parameter int NUM_SPRITES  = 4,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int MAZE_X0      = 120,
  parameter int MAZE_Y0      = 40,
  parameter int MAZE_W       = 400,
  parameter int MAZE_H       = 400,
  parameter int MAZE_AW      = 18,
  parameter int FLASH_FRAMES = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic                       blank,
  input  logic [10*NUM_SPRITES-1:0]  sprite_x,
  input  logic [10*NUM_SPRITES-1:0]  sprite_y,
  input  logic [NUM_SPRITES-1:0]     sprite_en,
  input  logic [4*NUM_SPRITES-1:0]   sprite_cidx,
  input  logic [9:0]                 sprite_r,
  input  logic                       fright,
  input  logic                       fright_end,
  input  logic                       pal_we,
  input  logic [3:0]                 pal_addr,
  input  logic [23:0]                pal_data,
  output logic [MAZE_AW-1:0]         maze_rom_addr,
  input  logic                       maze_rom_data,
  output logic [7:0]                 Red,
  output logic [7:0]                 Green,
  output logic [7:0]                 Blue
);

  // Elaboration-time sanity on the maze window geometry.
  if (MAZE_W * MAZE_H - 1 >= (1 << MAZE_AW)) begin : g_bad_aw
    $error("MAZE_AW cannot address MAZE_W*MAZE_H maze pixels");
  end
  if (MAZE_X0 + MAZE_W > H_ACTIVE || MAZE_Y0 + MAZE_H > V_ACTIVE) begin : g_bad_window
    $error("maze window extends past the active display");
  end

  localparam int CW = $clog2(2 * FLASH_FRAMES);

  localparam logic [10:0] X_LO = 11'(MAZE_X0);
  localparam logic [10:0] X_HI = 11'(MAZE_X0 + MAZE_W);
  localparam logic [10:0] Y_LO = 11'(MAZE_Y0);
  localparam logic [10:0] Y_HI = 11'(MAZE_Y0 + MAZE_H);

  // ---------------------------------------------------------------------------
  // Per-frame shadow of the sprite inputs and the flash frame counter. Loading
  // only at the frame boundary keeps a sprite from tearing across a frame.
  // ---------------------------------------------------------------------------
  logic [10*NUM_SPRITES-1:0] sh_x;
  logic [10*NUM_SPRITES-1:0] sh_y;
  logic [NUM_SPRITES-1:0]    sh_en;
  logic [4*NUM_SPRITES-1:0]  sh_cidx;
  logic [9:0]                sh_r;
  logic [CW-1:0]             frame_cnt;
  logic                      frame_tick;
  logic                      flash_hi;

  assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));
  assign flash_hi   = (frame_cnt >= CW'(FLASH_FRAMES));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sh_x      <= '0;
      sh_y      <= '0;
      sh_en     <= '0;
      sh_cidx   <= '0;
      sh_r      <= '0;
      frame_cnt <= '0;
    end else if (frame_tick) begin
      sh_x      <= sprite_x;
      sh_y      <= sprite_y;
      sh_en     <= sprite_en;
      sh_cidx   <= sprite_cidx;
      sh_r      <= sprite_r;
      frame_cnt <= (frame_cnt == CW'(2 * FLASH_FRAMES - 1)) ? '0 : frame_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Maze ROM addressing. The address leaves combinationally so the ROM bit
  // lines up with stage 1 and is consumed at the stage-2 edge.
  // ---------------------------------------------------------------------------
  logic               in_win;
  logic [MAZE_AW-1:0] col_off;
  logic [MAZE_AW-1:0] row_off;

  assign in_win = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                  ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);

  assign col_off = MAZE_AW'(DrawX) - MAZE_AW'(MAZE_X0);
  assign row_off = MAZE_AW'(DrawY) - MAZE_AW'(MAZE_Y0);

  assign maze_rom_addr = (in_win && !Reset) ? row_off * MAZE_AW'(MAZE_W) + col_off : '0;

  // ---------------------------------------------------------------------------
  // Stage 1: circle tests against the shadow sprite state.
  // ---------------------------------------------------------------------------
  logic [NUM_SPRITES-1:0] hit_now;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit u_hit (
      .draw_x   (DrawX),
      .draw_y   (DrawY),
      .center_x (sh_x[10*g +: 10]),
      .center_y (sh_y[10*g +: 10]),
      .radius   (sh_r),
      .en       (sh_en[g]),
      .hit      (hit_now[g])
    );
  end

  logic                   s1_blank;
  logic                   s1_win;
  logic [NUM_SPRITES-1:0] s1_hit;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_blank <= 1'b0;
      s1_win   <= 1'b0;
      s1_hit   <= '0;
    end else begin
      s1_blank <= blank;
      s1_win   <= in_win;
      s1_hit   <= hit_now;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: palette index selection and lookup.
  // ---------------------------------------------------------------------------
  rgb_t     palette [PAL_ENTRIES];
  pal_idx_t sel_idx;
  logic     found;

  // Lowest-numbered sprite wins. Ghosts give up their own colour while
  // frightened; PacMan (sprite 0) never does.
  always_comb begin
    sel_idx = PAL_BG;
    found   = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (!found && s1_hit[i]) begin
        found = 1'b1;
        if (i == 0 || !fright) begin
          sel_idx = sh_cidx[4*i +: 4];
        end else if (fright_end && flash_hi) begin
          sel_idx = PAL_FLASH;
        end else begin
          sel_idx = PAL_FRIGHT;
        end
      end
    end
    if (!found && s1_win && maze_rom_data) begin
      sel_idx = PAL_MAZE;
    end
  end

  // A write and a lookup on the same edge: the lookup sees the old entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        palette[i] <= reset_palette(pal_idx_t'(i));
      end
    end else if (pal_we) begin
      palette[pal_addr] <= rgb_t'(pal_data);
    end
  end

  rgb_t rgb_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= s1_blank ? palette[sel_idx] : rgb_t'(24'h000000);
    end
  end

  assign Red   = rgb_q.r;
  assign Green = rgb_q.g;
  assign Blue  = rgb_q.b;

endmodule

// File: tb/tb_sprite_color_mapper.sv
// tb/tb_sprite_color_mapper.sv - self-checking bench for sprite_color_mapper
module tb_sprite_color_mapper;

  localparam int NS = 4;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic [9:0]      DrawX = '0;
  logic [9:0]      DrawY = '0;
  logic            blank = 1'b1;
  logic [10*NS-1:0] sprite_x = '0;
  logic [10*NS-1:0] sprite_y = '0;
  logic [NS-1:0]   sprite_en = '0;
  logic [4*NS-1:0] sprite_cidx = '0;
  logic [9:0]      sprite_r = '0;
  logic            fright = 1'b0;
  logic            fright_end = 1'b0;
  logic            pal_we = 1'b0;
  logic [3:0]      pal_addr = '0;
  logic [23:0]     pal_data = '0;
  logic [17:0]     maze_rom_addr;
  logic            maze_rom_data = 1'b0;
  logic [7:0]      Red, Green, Blue;

  int nvec = 0;
  int nerr = 0;
  int rom_mode = 0;

  sprite_color_mapper #(.NUM_SPRITES(NS)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .blank         (blank),
    .sprite_x      (sprite_x),
    .sprite_y      (sprite_y),
    .sprite_en     (sprite_en),
    .sprite_cidx   (sprite_cidx),
    .sprite_r      (sprite_r),
    .fright        (fright),
    .fright_end    (fright_end),
    .pal_we        (pal_we),
    .pal_addr      (pal_addr),
    .pal_data      (pal_data),
    .maze_rom_addr (maze_rom_addr),
    .maze_rom_data (maze_rom_data),
    .Red           (Red),
    .Green         (Green),
    .Blue          (Blue)
  );

  always #5 Clk = ~Clk;

  function automatic bit rom_bit(int a);
    case (rom_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return bit'(((a * 37) >> 3) & 1);
    endcase
  endfunction

  // Synchronous maze ROM: data valid one cycle after the address.
  always @(posedge Clk) maze_rom_data <= rom_bit(int'(maze_rom_addr));

  // ---------------- reference model ----------------
  typedef struct {
    bit valid;
    bit blank;
    bit win;
    bit rom;
    int spr;
    int addr;
  } pix_t;

  int          m_sx[NS], m_sy[NS], m_cidx[NS];
  bit          m_en[NS];
  int          m_r, m_cnt;
  logic [23:0] m_pal[16];
  pix_t        st1;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_sx[i] = 0; m_sy[i] = 0; m_cidx[i] = 0; m_en[i] = 0;
    end
    m_r = 0;
    m_cnt = 0;
    for (int i = 0; i < 16; i++) m_pal[i] = 24'h000000;
    m_pal[1] = 24'h2121FF; m_pal[2] = 24'hFFFF00; m_pal[3] = 24'hFF0000;
    m_pal[4] = 24'hFFB8FF; m_pal[5] = 24'h00FFFF; m_pal[6] = 24'hFFB852;
    m_pal[8] = 24'h2121FF; m_pal[9] = 24'hFFFFFF;
  endtask

  task automatic check(string name, logic [23:0] got, logic [23:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s at %0t: got %06h expected %06h", name, $time, got, want);
    end
  endtask

  // One pixel clock: predict the colour emerging at this edge and the address
  // for the pixel now presented, advance the model, then compare.
  task automatic cycle();
    logic [23:0] exp_rgb;
    int idx, x, y;
    pix_t n;
    exp_rgb = 24'h000000;
    if (!Reset && st1.valid && st1.blank) begin
      if (st1.spr == 0) idx = m_cidx[0];
      else if (st1.spr > 0) idx = !fright ? m_cidx[st1.spr] : ((fright_end && m_cnt >= 16) ? 9 : 8);
      else if (st1.win && st1.rom) idx = 1;
      else idx = 0;
      exp_rgb = m_pal[idx];
    end
    x = int'(DrawX);
    y = int'(DrawY);
    n.valid = !Reset;
    n.blank = blank;
    n.win   = (x >= 120 && x < 520 && y >= 40 && y < 440);
    n.addr  = (Reset || !n.win) ? 0 : (y - 40) * 400 + (x - 120);
    n.rom   = rom_bit(n.addr);
    n.spr   = -1;
    for (int i = NS - 1; i >= 0; i--)
      if (m_en[i] && (x - m_sx[i]) * (x - m_sx[i]) + (y - m_sy[i]) * (y - m_sy[i]) <= m_r * m_r)
        n.spr = i;
    if (Reset) model_reset();
    else begin
      if (x == 0 && y == 480) begin
        for (int i = 0; i < NS; i++) begin
          m_sx[i]   = int'(sprite_x[10*i +: 10]);
          m_sy[i]   = int'(sprite_y[10*i +: 10]);
          m_cidx[i] = int'(sprite_cidx[4*i +: 4]);
          m_en[i]   = sprite_en[i];
        end
        m_r   = int'(sprite_r);
        m_cnt = (m_cnt + 1) % 32;
      end
      if (pal_we) m_pal[pal_addr] = pal_data;
    end
    st1 = n;
    @(posedge Clk);
    #1;
    check("rgb_model", {Red, Green, Blue}, exp_rgb);
    check("addr_model", 24'(maze_rom_addr), 24'(n.addr));
  endtask

  task automatic tick();
    DrawX = 10'd0; DrawY = 10'd480; blank = 1'b0;
    cycle();
  endtask

  // Present one visible pixel, then a blanked idle pixel; after the second
  // edge the output belongs to the visible pixel.
  task automatic show(int x, int y, string name, logic [23:0] want, int want_addr);
    DrawX = 10'(x); DrawY = 10'(y); blank = 1'b1;
    cycle();
    if (want_addr >= 0) check({name, "_addr"}, 24'(maze_rom_addr), 24'(want_addr));
    DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
    cycle();
    check(name, {Red, Green, Blue}, want);
  endtask

  task automatic set_sprite(int i, int x, int y, bit en, int cidx);
    sprite_x[10*i +: 10] = 10'(x);
    sprite_y[10*i +: 10] = 10'(y);
    sprite_en[i]         = en;
    sprite_cidx[4*i +: 4] = 4'(cidx);
  endtask

  initial begin
    int r, j, sx, sy;
    model_reset();
    st1 = '{valid: 0, blank: 0, win: 0, rom: 0, spr: -1, addr: 0};

    // 1: reset, then the first pixels out are black
    Reset = 1'b1; DrawX = 0; DrawY = 0; blank = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("reset_rgb", {Red, Green, Blue}, 24'h000000);
    end
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("post_reset_rgb", {Red, Green, Blue}, 24'h000000);
      check("post_reset_addr", 24'(maze_rom_addr), 24'h0);
    end

    // 2: single sprite, radius boundary and off-screen clipping
    set_sprite(0, 200, 200, 1, 2);
    sprite_r = 10'd8;
    tick();
    show(205, 205, "spr0_inside", 24'hFFFF00, -1);
    show(207, 207, "spr0_outside", 24'h000000, -1);
    show(208, 200, "spr0_on_radius", 24'hFFFF00, -1);
    set_sprite(0, 3, 3, 1, 2);
    tick();
    show(0, 0, "spr0_clip_left", 24'hFFFF00, -1);
    set_sprite(0, 1020, 3, 1, 2);
    tick();
    show(2, 3, "spr0_no_wrap", 24'h000000, -1);

    // 3: overlap priority
    set_sprite(0, 300, 300, 1, 2);
    set_sprite(1, 300, 300, 1, 3);
    tick();
    show(300, 300, "overlap_spr0_wins", 24'hFFFF00, -1);
    set_sprite(0, 300, 300, 0, 2);
    tick();
    show(300, 300, "overlap_spr1_only", 24'hFF0000, -1);

    // 4: sprite inputs changed mid-frame take effect only after the frame tick
    set_sprite(1, 400, 100, 1, 3);
    show(400, 100, "midframe_new_pos", 24'h000000, -1);
    show(300, 300, "midframe_old_pos", 24'hFF0000, -1);
    tick();
    show(400, 100, "nextframe_new_pos", 24'hFF0000, -1);
    show(300, 300, "nextframe_old_pos", 24'h000000, -1);

    // 5: frightened flashing over a full counter period (counter 1 after load)
    Reset = 1'b1; cycle(); Reset = 1'b0;
    set_sprite(1, 300, 300, 1, 3);
    tick();
    fright = 1'b1; fright_end = 1'b1;
    for (int k = 0; k < 32; k++) begin
      show(300, 300, "flash", (((k + 1) % 32) < 16) ? 24'h2121FF : 24'hFFFFFF, -1);
      tick();
    end
    show(300, 300, "flash_after_wrap", 24'h2121FF, -1);
    fright_end = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    show(300, 300, "fright_no_flash", 24'h2121FF, -1);
    fright = 1'b0;
    show(300, 300, "fright_off", 24'hFF0000, -1);

    // 6: maze window, blanking and palette writes
    rom_mode = 1;
    show(120, 40, "maze_corner", 24'h2121FF, 0);
    show(119, 40, "maze_left_of_window", 24'h000000, 0);
    show(121, 41, "maze_121_41", 24'h2121FF, 401);
    show(519, 439, "maze_last", 24'h2121FF, 159999);
    show(520, 439, "maze_right_of_window", 24'h000000, 0);
    DrawX = 130; DrawY = 50; blank = 1'b0;
    cycle();
    DrawX = 0; DrawY = 0;
    cycle();
    check("maze_blanked", {Red, Green, Blue}, 24'h000000);
    DrawX = 125; DrawY = 45; blank = 1'b1;
    cycle();
    pal_we = 1'b1; pal_addr = 4'd1; pal_data = 24'h00FF00;
    DrawX = 0; DrawY = 0; blank = 1'b0;
    cycle();
    check("pal_same_cycle_old", {Red, Green, Blue}, 24'h2121FF);
    pal_we = 1'b0;
    show(130, 50, "pal_new_value", 24'h00FF00, -1);

    // 7: randomized traffic against the model
    rom_mode = 2;
    for (int it = 0; it < 4000; it++) begin
      r = $urandom_range(0, 99);
      pal_we = 1'b0;
      if (r < 2) begin
        Reset = 1'b1;
        DrawX = 10'($urandom_range(0, 700)); DrawY = 10'($urandom_range(0, 520));
        blank = 1'($urandom);
        cycle();
        Reset = 1'b0;
        continue;
      end
      if (r < 7) begin
        tick();
        continue;
      end
      if (r < 17) begin
        j = $urandom_range(0, NS - 1);
        sx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 660);
        sy = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 500);
        set_sprite(j, sx, sy, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) sprite_r = 10'($urandom_range(0, 40));
      end
      if (r >= 17 && r < 23) begin
        pal_we = 1'b1; pal_addr = 4'($urandom); pal_data = 24'($urandom);
      end
      if ($urandom_range(0, 15) == 0) begin
        fright = 1'($urandom); fright_end = 1'($urandom);
      end
      if ($urandom_range(0, 1) == 0) begin
        j = $urandom_range(0, NS - 1);
        DrawX = 10'(m_sx[j] + $urandom_range(0, 2 * m_r + 6) - (m_r + 3));
        DrawY = 10'(m_sy[j] + $urandom_range(0, 2 * m_r + 6) - (m_r + 3));
      end else begin
        DrawX = 10'($urandom_range(0, 700));
        DrawY = 10'($urandom_range(0, 520));
      end
      blank = 1'($urandom_range(0, 9) != 0);
      if (DrawX == 10'd0 && DrawY == 10'd480) blank = 1'b0;
      cycle();
    end
    pal_we = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
